traffic_phase_ctrl: RTL

Parametrised N-approach traffic-light sequencer. It cycles green, yellow and all-red through N_DIR approaches in turn, and each approach has its own programmable green time. Yellow and all-red times are shared and programmable. Durations are adjusted at run time with a mode selector and three debounced buttons. The block advances on a single-cycle tick strobe in the clk_i domain, so no derived clocks are used. It sits between the board switch/button inputs and the RGB LED and 7-segment drivers.

---
 rtl/tl_pkg.sv | 19 +
 rtl/tl_btn_lockout.sv | 58 +++++
 rtl/traffic_phase_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tl_pkg.sv
// Shared encodings for the traffic phase controller: modes, light codes, phases, button bits.
package tl_pkg;

  localparam logic [1:0] MODE_NORMAL = 2'd0;
  localparam logic [1:0] MODE_ADJ_G  = 2'd1;
  localparam logic [1:0] MODE_ADJ_Y  = 2'd2;
  localparam logic [1:0] MODE_ADJ_R  = 2'd3;

  localparam logic [2:0] LIGHT_R = 3'b100;
  localparam logic [2:0] LIGHT_Y = 3'b010;
  localparam logic [2:0] LIGHT_G = 3'b001;

  typedef enum logic [1:0] {PH_G, PH_Y, PH_AR} phase_e;

  localparam int unsigned BTN_RESTORE = 0;
  localparam int unsigned BTN_INC     = 1;
  localparam int unsigned BTN_DEC     = 2;

endpackage

// File: rtl/tl_btn_lockout.sv
// Button acceptance: a press is taken only while idle, then locks out for DB_CYC cycles.
// Emits one-cycle restore/inc/dec pulses with restore > inc > dec priority.
module tl_btn_lockout
  import tl_pkg::*;
#(
  parameter int unsigned DB_CYC = 25000000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [2:0] btn_i,
  input  logic       en_i,
  output logic       restore_o,
  output logic       inc_o,
  output logic       dec_o
);

  localparam int unsigned CNT_W = $clog2(DB_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             idle;
  logic             accept;

  assign idle   = (cnt_q == '0);
  assign accept = en_i && idle && (|btn_i);

  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = CNT_W'(DB_CYC);
    end else if (!idle) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_comb begin
    restore_o = 1'b0;
    inc_o     = 1'b0;
    dec_o     = 1'b0;
    if (accept) begin
      if (btn_i[BTN_RESTORE]) begin
        restore_o = 1'b1;
      end else if (btn_i[BTN_INC]) begin
        inc_o = 1'b1;
      end else begin
        dec_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// N-approach G -> Y -> all-red sequencer with per-approach green and shared Y/AR lengths.
// Define TL_PED_EN to add sticky pedestrian requests that extend the next green and drive walk_o.
module traffic_phase_ctrl
  import tl_pkg::*;
#(
  parameter int unsigned N_DIR   = 2,
  parameter int unsigned TIME_W  = 4,
  parameter int unsigned TMAX    = 15,
  parameter int unsigned DEF_G   = 10,
  parameter int unsigned DEF_Y   = 3,
  parameter int unsigned DEF_R   = 2,
  parameter int unsigned DB_CYC  = 25000000,
  parameter int unsigned PED_EXT = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     tick_i,
  input  logic [1:0]               mode_i,
  input  logic [$clog2(N_DIR)-1:0] sel_i,
  input  logic [2:0]               btn_i,
  input  logic [N_DIR-1:0]         ped_req_i,
  output logic [3*N_DIR-1:0]       light_o,
  output logic [TIME_W-1:0]        time_o,
  output logic [$clog2(N_DIR)-1:0] dir_o,
  output logic [N_DIR-1:0]         walk_o
);

  localparam int unsigned DIR_W = $clog2(N_DIR);

  localparam logic [TIME_W-1:0] DEF_G_T = TIME_W'(DEF_G);
  localparam logic [TIME_W-1:0] DEF_Y_T = TIME_W'(DEF_Y);
  localparam logic [TIME_W-1:0] DEF_R_T = TIME_W'(DEF_R);
  localparam logic [TIME_W-1:0] TMAX_T  = TIME_W'(TMAX);
  localparam logic [TIME_W-1:0] ONE_T   = TIME_W'(1);

  localparam logic [N_DIR-1:0][2:0] LIGHT_RST = {{(N_DIR-1){LIGHT_R}}, LIGHT_G};

  phase_e                       phase_q, phase_d;
  logic [DIR_W-1:0]             dir_q, dir_d, dir_nxt;
  logic [TIME_W-1:0]            ctime_q, ctime_d;
  logic [TIME_W-1:0]            green_load;
  logic                         walk_act_q, walk_act_d;
  logic                         walk_grant;
  logic                         green_entry;

  logic [N_DIR-1:0][TIME_W-1:0] glen_q, glen_d;
  logic [TIME_W-1:0]            ylen_q, ylen_d;
  logic [TIME_W-1:0]            rlen_q, rlen_d;

  logic                         sel_ok;
  logic                         btn_en;
  logic                         do_restore, do_inc, do_dec;

  logic [N_DIR-1:0][2:0]        light_q, light_d;
  logic [TIME_W-1:0]            time_q, time_d;
  logic [DIR_W-1:0]             dir_out_q;
  logic [N_DIR-1:0]             walk_q, walk_d;

  assign dir_nxt     = (dir_q == DIR_W'(N_DIR - 1)) ? '0 : dir_q + DIR_W'(1);
  assign green_entry = tick_i && (ctime_q <= ONE_T) && (phase_q == PH_AR);
  assign sel_ok      = (32'(sel_i) < N_DIR);
  // An out-of-range approach select swallows the press without starting a lockout.
  assign btn_en      = !((mode_i == MODE_ADJ_G) && !sel_ok);

  tl_btn_lockout #(
    .DB_CYC (DB_CYC)
  ) u_btn_lockout (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .btn_i     (btn_i),
    .en_i      (btn_en),
    .restore_o (do_restore),
    .inc_o     (do_inc),
    .dec_o     (do_dec)
  );

`ifdef TL_PED_EN
  localparam logic [31:0] TFULL = (32'd1 << TIME_W) - 32'd1;

  logic [N_DIR-1:0] latch_q, latch_d;
  logic [31:0]      ext_sum;

  assign walk_grant = latch_q[dir_nxt];
  assign ext_sum    = 32'(glen_q[dir_nxt]) + PED_EXT;
  assign green_load = !walk_grant     ? glen_q[dir_nxt] :
                      (ext_sum > TFULL) ? {TIME_W{1'b1}} : ext_sum[TIME_W-1:0];

  // A request seen in the entry cycle itself is kept for the following green.
  always_comb begin
    latch_d = latch_q;
    if (green_entry) begin
      latch_d[dir_nxt] = 1'b0;
    end
    latch_d = latch_d | ped_req_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      latch_q <= '0;
    end else begin
      latch_q <= latch_d;
    end
  end
`else
  logic unused_ped;

  assign unused_ped = ^ped_req_i;
  assign walk_grant = 1'b0;
  assign green_load = glen_q[dir_nxt];
`endif

  function automatic logic [TIME_W-1:0] adjust(input logic [TIME_W-1:0] cur,
                                                input logic [TIME_W-1:0] def,
                                                input logic              restore,
                                                input logic              inc,
                                                input logic              dec);
    if (restore) return def;
    if (inc)     return (cur >= TMAX_T) ? TMAX_T : cur + ONE_T;
    if (dec)     return (cur <= ONE_T) ? ONE_T : cur - ONE_T;
    return cur;
  endfunction

  always_ff @(posedge clk_i or negedge rst_i) begin : fsm_state
    if (!rst_i) begin
      phase_q    <= PH_G;
      dir_q      <= '0;
      ctime_q    <= DEF_G_T;
      walk_act_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      dir_q      <= dir_d;
      ctime_q    <= ctime_d;
      walk_act_q <= walk_act_d;
    end
  end

  always_comb begin : fsm_next
    phase_d    = phase_q;
    dir_d      = dir_q;
    ctime_d    = ctime_q;
    walk_act_d = walk_act_q;
    if (tick_i) begin
      if (ctime_q > ONE_T) begin
        ctime_d = ctime_q - ONE_T;
      end else begin
        case (phase_q)
          PH_G: begin
            phase_d    = PH_Y;
            ctime_d    = ylen_q;
            walk_act_d = 1'b0;
          end
          PH_Y: begin
            phase_d = PH_AR;
            ctime_d = rlen_q;
          end
          PH_AR: begin
            phase_d    = PH_G;
            dir_d      = dir_nxt;
            ctime_d    = green_load;
            walk_act_d = walk_grant;
          end
          default: begin
            phase_d = PH_G;
            ctime_d = DEF_G_T;
          end
        endcase
      end
    end
  end

  always_comb begin : fsm_out
    light_d = {N_DIR{LIGHT_R}};
    time_d  = ctime_q;
    walk_d  = '0;
    case (mode_i)
      MODE_NORMAL: begin
        if (phase_q == PH_G) begin
          light_d[dir_q] = LIGHT_G;
        end else if (phase_q == PH_Y) begin
          light_d[dir_q] = LIGHT_Y;
        end
      end
      MODE_ADJ_G: begin
        if (sel_ok) begin
          light_d[sel_i] = LIGHT_G;
          time_d         = glen_q[sel_i];
        end else begin
          time_d = '0;
        end
      end
      MODE_ADJ_Y: begin
        light_d = {N_DIR{LIGHT_Y}};
        time_d  = ylen_q;
      end
      MODE_ADJ_R: begin
        time_d = rlen_q;
      end
    endcase
    if (walk_act_q && (phase_q == PH_G)) begin
      walk_d[dir_q] = 1'b1;
    end
  end

  // Lengths change only here; the running countdown keeps its loaded value.
  always_comb begin : len_next
    glen_d = glen_q;
    ylen_d = ylen_q;
    rlen_d = rlen_q;
    case (mode_i)
      MODE_ADJ_G: begin
        if (sel_ok) begin
          glen_d[sel_i] = adjust(glen_q[sel_i], DEF_G_T, do_restore, do_inc, do_dec);
        end
      end
      MODE_ADJ_Y: ylen_d = adjust(ylen_q, DEF_Y_T, do_restore, do_inc, do_dec);
      MODE_ADJ_R: rlen_d = adjust(rlen_q, DEF_R_T, do_restore, do_inc, do_dec);
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin : len_regs
    if (!rst_i) begin
      glen_q <= {N_DIR{DEF_G_T}};
      ylen_q <= DEF_Y_T;
      rlen_q <= DEF_R_T;
    end else begin
      glen_q <= glen_d;
      ylen_q <= ylen_d;
      rlen_q <= rlen_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin : out_regs
    if (!rst_i) begin
      light_q   <= LIGHT_RST;
      time_q    <= DEF_G_T;
      dir_out_q <= '0;
      walk_q    <= '0;
    end else begin
      light_q   <= light_d;
      time_q    <= time_d;
      dir_out_q <= dir_q;
      walk_q    <= walk_d;
    end
  end

  assign light_o = light_q;
  assign time_o  = time_q;
  assign dir_o   = dir_out_q;
  assign walk_o  = walk_q;

endmodule
